rob: RTL and testbench
======================

# rob

Three-wide reorder buffer between rename/dispatch and the architectural RAT/freelist. It allocates up to three entries per cycle in program order and collects completion and exception status from three writeback ports. It presents up to three in-order retire slots per cycle on the `*_ret` bus consumed by the ARAT. When an excepting instruction retires, it flushes all younger state.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `P_W`, 5: physical register tag width.
- `R_W`, 3: architectural register index width.
- `TAG_W`, $clog2(DEPTH): ROB index width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `alloc_valid` in [2:0] x1: allocation requests; legal patterns are 000, 001, 011, 111.
- `alloc_Type` in [2:0] x2: instruction class; 2'b11 means no register write.
- `alloc_Pw` in [2:0] x P_W: new physical destination.
- `alloc_Rw` in [2:0] x R_W: architectural destination.
- `alloc_ready` out 1: at least 3 free entries and no flush in progress.
- `alloc_tag` out [2:0] x TAG_W: index assigned to each slot.
- `wb_valid` in [2:0] x1: writeback completion.
- `wb_tag` in [2:0] x TAG_W: completing entry.
- `wb_excep` in [2:0] x1: completing instruction raised an exception.
- `ready_ret` out [2:0] x1: retire slot k is valid this cycle.
- `excep_ret` out [2:0] x1: retiring entry carries an exception.
- `Type_ret`, `Pw_ret`, `Rw_ret` out [2:0]: fields of the retiring entries.
- `flush` out 1: one-cycle pulse in the cycle after an excepting retire.

## Operation
- Entry fields: valid, complete, excep, Type, Pw, Rw. State also includes `head`, `tail` (TAG_W bits each, wrap mod DEPTH) and `count` (TAG_W+1 bits).
- Allocation occurs when alloc_valid[k] & alloc_ready.
  - alloc_tag[k] = tail + k, mod DEPTH.
  - The entry is written with valid=1, complete=0, excep=0.
  - tail advances by the number of valid slots.
- Writeback: on wb_valid[k], set complete=1 and excep=wb_excep[k] at entry wb_tag[k].
  - Writeback to an invalid entry is ignored.
  - Ports target distinct tags; behaviour is undefined otherwise.
- Retire selection is combinational from registered state:
  - ready_ret[k] = entry(head+k) valid & complete & k < count & ready_ret[j] for all j<k & !excep of all earlier slots.
  - An excepting entry retires in its slot with excep_ret=1. No later slot retires in that cycle.
- Normal update: head += nret; count += nalloc − nret.
- Exception retire edge:
  - All valid bits clear.
  - head = tail = head + nret.
  - count = 0.
  - Same-cycle allocations and writebacks are dropped.
  - flush register is set to 1.
- Flush cycle: alloc_ready=0, ready_ret=0, writebacks ignored. flush returns to 0 on the next edge.

## Timing
- Reset values:
  - head = tail = count = 0; all valid = 0; flush = 0.
  - ready_ret = excep_ret = 0; alloc_ready = 1; alloc_tag = {0,1,2}.
- An allocated entry becomes eligible for retire no earlier than 1 cycle after its writeback edge. Writeback becomes visible 1 cycle after wb_valid.
- Retire outputs are valid in the same cycle the head entries are complete. Head advances on that edge, and the ARAT samples on the same edge.
- alloc_ready = (count ≤ DEPTH−3) & !flush, from registered count. There is no bypass of same-cycle retirements.
- When full (count=DEPTH), alloc_ready=0 and retirement still proceeds.
- Wrap-around: all index arithmetic is mod DEPTH. count distinguishes full from empty.
- Simultaneous alloc, writeback and retire in one cycle are all legal and take effect on the same edge.
- Reset mid-operation discards all entries immediately. No flush pulse is produced.

## Structure
- `rob_pkg` holds:
  - `TYPE_NOWB` = 2'b11.
  - Default `DEPTH`, `P_W`, `R_W`.
  - `rob_entry_t` packed struct (valid, complete, excep, Type, Pw, Rw).
- Sub-module `rob_retire_sel`: purely combinational.
  - Inputs: three head entries and count.
  - Outputs: ready_ret, excep_ret, nret, exc_hit.

## Test plan
- Reset, then allocate 3 (Type 00, Pw 8/9/10, Rw 1/2/3), then writeback all three -> next cycle ready_ret=111 with those fields, and count returns to 0.
- Writeback order tag2, tag0, tag1 on separate cycles -> retire slot 0 after tag0's writeback, slots 1 and 2 together after tag1's writeback.
- Three entries complete, with the middle one excepting -> ready_ret=011, excep_ret=010, flush=1 next cycle, alloc_ready=0 during flush, and count=0 after.
- Allocate 3 per cycle with no writeback -> alloc_ready drops when count=15. Then retire 3 -> alloc_ready rises the following cycle.
- Run 40 alloc/retire cycles -> tags wrap 15→0 correctly, and retired Pw sequence matches allocation order.
- Assert rst low with 5 entries in flight -> all outputs return to reset values asynchronously, and flush stays 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and defaults for the three-wide reorder buffer.
//   ROB_DEPTH / ROB_P_W / ROB_R_W : default entry count and field widths
//   TYPE_NOWB                     : instruction class that writes no register
//   rob_entry_t                   : one ROB entry (valid, complete, excep, Type, Pw, Rw)
//   popcnt3                       : population count of a 3-bit slot mask
package rob_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_P_W   = 5;
   localparam int ROB_R_W   = 3;

   localparam logic [1:0] TYPE_NOWB = 2'b11;

   // Entry field widths follow the package defaults; the top-level P_W/R_W
   // parameters must stay equal to ROB_P_W/ROB_R_W.
   typedef struct packed {
      logic                valid;
      logic                complete;
      logic                excep;
      logic [1:0]          typ;
      logic [ROB_P_W-1:0]  pw;
      logic [ROB_R_W-1:0]  rw;
   } rob_entry_t;

   function automatic logic [1:0] popcnt3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational in-order retire selection over the three oldest entries.
//   i_head      : entries at head, head+1, head+2
//   i_count     : occupied entries
//   o_ready_ret : slot k retires this cycle
//   o_excep_ret : retiring slot k carries an exception
//   o_nret      : number of retiring slots
//   o_exc_hit   : an excepting entry retires this cycle
//   o_type/o_pw/o_rw : head entry fields presented on the retire bus
module rob_retire_sel
   import rob_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  rob_entry_t [2:0]              i_head,
   input  logic [TAG_W:0]                i_count,
   output logic [2:0]                    o_ready_ret,
   output logic [2:0]                    o_excep_ret,
   output logic [1:0]                    o_nret,
   output logic                          o_exc_hit,
   output logic [2:0][1:0]               o_type,
   output logic [2:0][ROB_P_W-1:0]       o_pw,
   output logic [2:0][ROB_R_W-1:0]       o_rw
);

   logic [2:0] w_ok;

   always_comb begin
      w_ok        = '0;
      o_ready_ret = '0;
      o_excep_ret = '0;
      o_type      = '0;
      o_pw        = '0;
      o_rw        = '0;
      for (int k = 0; k < 3; k++) begin
         w_ok[k]   = i_head[k].valid & i_head[k].complete & (i_count > (TAG_W+1)'(k));
         o_type[k] = i_head[k].typ;
         o_pw[k]   = i_head[k].pw;
         o_rw[k]   = i_head[k].rw;
      end
      // A slot retires only behind a retiring, non-excepting older slot.
      o_ready_ret[0] = w_ok[0];
      o_ready_ret[1] = o_ready_ret[0] & ~i_head[0].excep & w_ok[1];
      o_ready_ret[2] = o_ready_ret[1] & ~i_head[1].excep & w_ok[2];
      for (int k = 0; k < 3; k++)
         o_excep_ret[k] = o_ready_ret[k] & i_head[k].excep;
   end

   assign o_nret    = popcnt3(o_ready_ret);
   assign o_exc_hit = |o_excep_ret;

endmodule

// File: rtl/rob.sv
// Three-wide reorder buffer between rename/dispatch and the ARAT/freelist.
//   clk, rst (async, active-low)
//   alloc_valid/Type/Pw/Rw -> alloc_ready, alloc_tag : in-order allocation
//   wb_valid/wb_tag/wb_excep                          : completion status
//   ready_ret/excep_ret/Type_ret/Pw_ret/Rw_ret        : in-order retire bus
//   flush                                             : pulse after an excepting retire
module rob
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int P_W   = ROB_P_W,
   parameter int R_W   = ROB_R_W,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             alloc_valid,
   input  logic [2:0][1:0]        alloc_Type,
   input  logic [2:0][P_W-1:0]    alloc_Pw,
   input  logic [2:0][R_W-1:0]    alloc_Rw,
   output logic                   alloc_ready,
   output logic [2:0][TAG_W-1:0]  alloc_tag,
   input  logic [2:0]             wb_valid,
   input  logic [2:0][TAG_W-1:0]  wb_tag,
   input  logic [2:0]             wb_excep,
   output logic [2:0]             ready_ret,
   output logic [2:0]             excep_ret,
   output logic [2:0][1:0]        Type_ret,
   output logic [2:0][P_W-1:0]    Pw_ret,
   output logic [2:0][R_W-1:0]    Rw_ret,
   output logic                   flush
);

   rob_entry_t        r_mem [DEPTH];
   logic [TAG_W-1:0]  r_head;
   logic [TAG_W-1:0]  r_tail;
   logic [TAG_W:0]    r_count;
   logic              r_flush;

   rob_entry_t [2:0]  w_head_ent;
   logic [2:0]        w_alloc_en;
   logic [1:0]        w_nalloc;
   logic [1:0]        w_nret;
   logic              w_exc_hit;

   // No bypass of same-cycle retirement: readiness uses the registered count.
   assign alloc_ready = (r_count <= (TAG_W+1)'(DEPTH-3)) & ~r_flush;
   assign w_alloc_en  = alloc_valid & {3{alloc_ready}};
   assign w_nalloc    = popcnt3(w_alloc_en);
   assign flush       = r_flush;

   always_comb begin
      alloc_tag  = '0;
      w_head_ent = '0;
      for (int k = 0; k < 3; k++) begin
         alloc_tag[k]  = r_tail + TAG_W'(k);
         w_head_ent[k] = r_mem[r_head + TAG_W'(k)];
      end
   end

   // During the flush cycle count is zero, which keeps the retire bus idle.
   rob_retire_sel #(.TAG_W(TAG_W)) u_sel (
      .i_head      (w_head_ent),
      .i_count     (r_count),
      .o_ready_ret (ready_ret),
      .o_excep_ret (excep_ret),
      .o_nret      (w_nret),
      .o_exc_hit   (w_exc_hit),
      .o_type      (Type_ret),
      .o_pw        (Pw_ret),
      .o_rw        (Rw_ret)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_flush <= 1'b0;
      end else begin
         r_flush <= 1'b0;
         if (w_exc_hit) begin
            // Everything younger than the excepting entry is discarded,
            // including this cycle's allocations and writebacks.
            for (int i = 0; i < DEPTH; i++)
               r_mem[i].valid <= 1'b0;
            r_head  <= r_head + TAG_W'(w_nret);
            r_tail  <= r_head + TAG_W'(w_nret);
            r_count <= '0;
            r_flush <= 1'b1;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (wb_valid[k] && !r_flush && r_mem[wb_tag[k]].valid) begin
                  r_mem[wb_tag[k]].complete <= 1'b1;
                  r_mem[wb_tag[k]].excep    <= wb_excep[k];
               end
            end
            for (int k = 0; k < 3; k++)
               if (ready_ret[k])
                  r_mem[r_head + TAG_W'(k)].valid <= 1'b0;
            // alloc_ready caps count at DEPTH-3, so new slots never alias
            // the entries retiring on this edge.
            for (int k = 0; k < 3; k++) begin
               if (w_alloc_en[k]) begin
                  r_mem[r_tail + TAG_W'(k)].valid    <= 1'b1;
                  r_mem[r_tail + TAG_W'(k)].complete <= 1'b0;
                  r_mem[r_tail + TAG_W'(k)].excep    <= 1'b0;
                  r_mem[r_tail + TAG_W'(k)].typ      <= alloc_Type[k];
                  r_mem[r_tail + TAG_W'(k)].pw       <= alloc_Pw[k];
                  r_mem[r_tail + TAG_W'(k)].rw       <= alloc_Rw[k];
               end
            end
            r_head  <= r_head + TAG_W'(w_nret);
            r_tail  <= r_tail + TAG_W'(w_nalloc);
            r_count <= r_count + (TAG_W+1)'(w_nalloc) - (TAG_W+1)'(w_nret);
         end
      end
   end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer: allocations push expected retire
// records, a negedge monitor pops and compares whatever the DUT retires.
module tb_rob;
   import rob_pkg::*;

   localparam int DEPTH = 16;
   localparam int P_W   = 5;
   localparam int R_W   = 3;
   localparam int TAG_W = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [2:0]             alloc_valid;
   logic [2:0][1:0]        alloc_Type;
   logic [2:0][P_W-1:0]    alloc_Pw;
   logic [2:0][R_W-1:0]    alloc_Rw;
   logic                   alloc_ready;
   logic [2:0][TAG_W-1:0]  alloc_tag;
   logic [2:0]             wb_valid;
   logic [2:0][TAG_W-1:0]  wb_tag;
   logic [2:0]             wb_excep;
   logic [2:0]             ready_ret;
   logic [2:0]             excep_ret;
   logic [2:0][1:0]        Type_ret;
   logic [2:0][P_W-1:0]    Pw_ret;
   logic [2:0][R_W-1:0]    Rw_ret;
   logic                   flush;

   always #5 clk = ~clk;

   rob #(.DEPTH(DEPTH), .P_W(P_W), .R_W(R_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_Type(alloc_Type), .alloc_Pw(alloc_Pw),
      .alloc_Rw(alloc_Rw), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_excep(wb_excep),
      .ready_ret(ready_ret), .excep_ret(excep_ret), .Type_ret(Type_ret),
      .Pw_ret(Pw_ret), .Rw_ret(Rw_ret), .flush(flush)
   );

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic             excep;
      logic [1:0]       typ;
      logic [P_W-1:0]   pw;
      logic [R_W-1:0]   rw;
   } exp_t;

   exp_t             exp_q[$];
   logic [TAG_W-1:0] pend_q[$];
   logic [TAG_W-1:0] m_tail;
   int               checks   = 0;
   int               failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Retire monitor
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            if (ready_ret[k] === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL ret_unexpected slot=%0d actual_pw=%0d expected=none", k, Pw_ret[k]);
               end else begin
                  mon_e = exp_q.pop_front();
                  if ({excep_ret[k], Type_ret[k], Pw_ret[k], Rw_ret[k]} !==
                      {mon_e.excep, mon_e.typ, mon_e.pw, mon_e.rw}) begin
                     failures++;
                     $display("FAIL ret_fields slot=%0d actual(ex,ty,pw,rw)=%0d,%0d,%0d,%0d expected=%0d,%0d,%0d,%0d",
                              k, excep_ret[k], Type_ret[k], Pw_ret[k], Rw_ret[k],
                              mon_e.excep, mon_e.typ, mon_e.pw, mon_e.rw);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      alloc_valid = '0;
      wb_valid    = '0;
      wb_excep    = '0;
   endtask

   task automatic alloc3(input int n, input int pw0, input int rw0, input logic [1:0] typ);
      exp_t e;
      alloc_valid = (n == 3) ? 3'b111 : (n == 2) ? 3'b011 : (n == 1) ? 3'b001 : 3'b000;
      for (int k = 0; k < n; k++) begin
         alloc_Pw[k]   = P_W'(pw0 + k);
         alloc_Rw[k]   = R_W'(rw0 + k);
         alloc_Type[k] = typ;
         e.tag   = m_tail + TAG_W'(k);
         e.excep = 1'b0;
         e.typ   = typ;
         e.pw    = P_W'(pw0 + k);
         e.rw    = R_W'(rw0 + k);
         exp_q.push_back(e);
         pend_q.push_back(e.tag);
      end
      m_tail = m_tail + TAG_W'(n);
   endtask

   task automatic wb(input int k, input logic [TAG_W-1:0] tag, input logic ex);
      wb_valid[k] = 1'b1;
      wb_tag[k]   = tag;
      wb_excep[k] = ex;
      if (ex) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].tag == tag) begin
               exp_q[i].excep = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic wb_next(input int n);
      for (int k = 0; k < n; k++)
         if (pend_q.size() > 0)
            wb(k, pend_q.pop_front(), 1'b0);
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 0;
      while ((exp_q.size() > 0 || pend_q.size() > 0) && budget < 60) begin
         wb_next(3);
         tick();
         budget++;
      end
      chk({name, "_budget"}, 32'(budget < 60), 32'd1);
      #1;
      chk({name, "_count"}, 32'(dut.r_count), 32'd0);
   endtask

   initial begin
      alloc_valid = '0; alloc_Type = '0; alloc_Pw = '0; alloc_Rw = '0;
      wb_valid = '0; wb_tag = '0; wb_excep = '0;
      m_tail = '0;

      // reset state
      #12;
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_alloc_tag",   32'(alloc_tag),   32'h210);
      chk("rst_ready_ret",   32'(ready_ret),   32'd0);
      chk("rst_excep_ret",   32'(excep_ret),   32'd0);
      chk("rst_flush",       32'(flush),       32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // basic allocate / writeback / retire
      alloc3(3, 8, 1, 2'b00);
      tick();
      wb(0, 4'd0, 1'b0); wb(1, 4'd1, 1'b0); wb(2, 4'd2, 1'b0);
      #1 chk("t1_no_early_ret", 32'(ready_ret), 32'd0);
      tick();
      #1 chk("t1_ready_ret", 32'(ready_ret), 32'b111);
      tick();
      #1 chk("t1_count", 32'(dut.r_count), 32'd0);
      chk("t1_idle", 32'(ready_ret), 32'd0);
      pend_q.delete();

      // out-of-order writeback, in-order retire
      alloc3(3, 11, 4, 2'b01);
      tick();
      wb(0, 4'd5, 1'b0);
      #1 chk("t2_c0", 32'(ready_ret), 32'd0);
      tick();
      wb(0, 4'd3, 1'b0);
      #1 chk("t2_c1", 32'(ready_ret), 32'd0);
      tick();
      #1 chk("t2_c2", 32'(ready_ret), 32'b001);
      tick();
      wb(0, 4'd4, 1'b0);
      #1 chk("t2_c3", 32'(ready_ret), 32'd0);
      tick();
      #1 chk("t2_c4", 32'(ready_ret), 32'b011);
      tick();
      #1 chk("t2_count", 32'(dut.r_count), 32'd0);
      pend_q.delete();

      // exception in the middle slot
      alloc3(3, 14, 7, TYPE_NOWB);
      tick();
      wb(0, 4'd6, 1'b0); wb(1, 4'd7, 1'b1); wb(2, 4'd8, 1'b0);
      tick();
      #1 chk("t3_ready_ret", 32'(ready_ret), 32'b011);
      chk("t3_excep_ret", 32'(excep_ret), 32'b010);
      chk("t3_flush_pre", 32'(flush), 32'd0);
      tick();
      exp_q.delete();
      pend_q.delete();
      alloc_valid = 3'b111;
      wb(0, 4'd8, 1'b0);
      #1 chk("t3_flush", 32'(flush), 32'd1);
      chk("t3_alloc_ready_flush", 32'(alloc_ready), 32'd0);
      chk("t3_ret_flush", 32'(ready_ret), 32'd0);
      chk("t3_count_flush", 32'(dut.r_count), 32'd0);
      tick();
      #1 chk("t3_flush_end", 32'(flush), 32'd0);
      chk("t3_alloc_ready_post", 32'(alloc_ready), 32'd1);
      chk("t3_tail", 32'(alloc_tag[0]), 32'd8);
      chk("t3_count_post", 32'(dut.r_count), 32'd0);
      m_tail = 4'd8;

      // fill to 15, then retire 3
      for (int i = 0; i < 5; i++) begin
         #1 chk("t4_ready_fill", 32'(alloc_ready), 32'd1);
         alloc3(3, i * 3, 0, 2'b10);
         tick();
      end
      #1 chk("t4_ready_full", 32'(alloc_ready), 32'd0);
      chk("t4_count15", 32'(dut.r_count), 32'd15);
      alloc_valid = 3'b111;
      tick();
      #1 chk("t4_no_overalloc", 32'(dut.r_count), 32'd15);
      wb_next(3);
      tick();
      #1 chk("t4_ret_full", 32'(ready_ret), 32'b111);
      chk("t4_ready_still_low", 32'(alloc_ready), 32'd0);
      tick();
      #1 chk("t4_ready_rise", 32'(alloc_ready), 32'd1);
      drain("t4_drain");

      // sustained alloc/retire with tag wrap
      for (int i = 0; i < 40; i++) begin
         #1 chk("t5_tag", 32'(alloc_tag[0]), 32'(m_tail));
         chk("t5_ready", 32'(alloc_ready), 32'd1);
         wb_next(3);
         alloc3(3, (i * 7) % 32, i % 8, 2'(i % 4));
         tick();
      end
      drain("t5_drain");
      chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // reset with entries in flight
      alloc3(3, 20, 1, 2'b00);
      tick();
      alloc3(2, 23, 4, 2'b00);
      wb_next(3);
      tick();
      #1 chk("t6_ret_before", 32'(ready_ret), 32'b111);
      rst = 1'b0;
      #1 chk("t6_ret", 32'(ready_ret), 32'd0);
      chk("t6_excep", 32'(excep_ret), 32'd0);
      chk("t6_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("t6_alloc_tag", 32'(alloc_tag), 32'h210);
      chk("t6_flush", 32'(flush), 32'd0);
      chk("t6_count", 32'(dut.r_count), 32'd0);
      exp_q.delete();
      pend_q.delete();
      repeat (2) @(posedge clk);
      #1 chk("t6_flush_hold", 32'(flush), 32'd0);
      rst = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
